row_separator: RTL and testbench
================================

// Module: row_separator
// PURPOSE
//  Splits one 8x32 reference block, packed column-major, into eight 32-pixel row buses.
//  Sits between the reference-memory read port and the DMT ME row engines.
//  Input word = 32 column words of 8 pixels each; outputs are registered (1-cycle latency).
// PARAMETERS
//  PIXEL   8   bits per pixel
//  ROWS    8   pixels per column word = number of row outputs (fixed 8; port list assumes 8)
//  COLS    32  column words per input = pixels per output row
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous active-low reset
//  in_valid   in   1               ref_ou carries a new block this cycle
//  ref_ou     in   ROWS*COLS*PIXEL packed block; column c = ref_ou[c*ROWS*PIXEL +: ROWS*PIXEL]
//  out_valid  out  1               ref_row1..8 hold a newly separated block
//  ref_row1   out  COLS*PIXEL      row 1 (top) pixels, column 0 at LSB
//  ref_row2..ref_row8  out  COLS*PIXEL  rows 2..8, same layout
// BEHAVIOUR
//  - Mapping, for row r in 1..8, column j in 0..31:
//    ref_rowr[j*PIXEL +: PIXEL] = ref_ou[j*8*PIXEL + (8-r)*PIXEL +: PIXEL]
//    (MS pixel of each column word -> row1, LS pixel -> row8).
//  - Reset (rst_n=0, async): all ref_rowN = 0, out_valid = 0; held until rst_n rises.
//  - Each clk edge with in_valid=1: all eight rows load the separated ref_ou; out_valid <= 1.
//  - Edge with in_valid=0: out_valid <= 0; row registers hold their previous value.
//  - Latency exactly 1 cycle; back-to-back in_valid accepted every cycle, no stall, no backpressure.
//  - All eight rows update on the same edge; never a partial update.
//  - Reset asserted mid-stream: outputs clear immediately; the first post-reset block appears
//    1 cycle after the first in_valid.
//  - Pure bit rearrangement; no arithmetic, no width change per pixel.
// CONFIGURATION
//  ROW_SEP_ZERO_INVALID_EN
//   defined:   while out_valid=0 all ref_rowN are driven 0 (gated after the registers).
//   undefined: ref_rowN always show register contents (last accepted block held).
// TESTING
//  1 Reset: rst_n=0 -> out_valid=0, all rows 0; release rst_n with in_valid=0 -> unchanged.
//  2 ref_ou = 32 copies of 64'hFFFFFFFF_00000000, in_valid=1 -> next cycle rows1-4 all-FF,
//    rows5-8 all-00, out_valid=1.
//  3 Column ramp: column word c = {8{c[7:0]}} (c=0..31) -> every row = {8'h1f,...,8'h01,8'h00},
//    i.e. pixel j = j in all eight rows.
//  4 Row ramp: every column word = 64'h0102030405060708 -> row r all pixels = r.
//  5 Two back-to-back in_valid blocks then in_valid=0 -> two consecutive out_valid cycles with
//    matching data, then out_valid=0; rows hold block 2 (or 0 with ROW_SEP_ZERO_INVALID_EN).
//  6 rst_n pulsed low mid-stream -> rows/out_valid clear asynchronously, before the next edge.

Source files
------------

// File: rtl/row_separator_if.sv
// Block/row bus between the reference-memory read port and the row separator.
// The slave modport is the separator. The master modport is its upstream driver and downstream consumer.
interface row_separator_if #(
  parameter int unsigned PIXEL = 8,
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 32
);
  logic                          in_valid;
  logic [ROWS*COLS*PIXEL-1:0]    ref_ou;
  logic                          out_valid;
  logic [COLS*PIXEL-1:0]         ref_row1;
  logic [COLS*PIXEL-1:0]         ref_row2;
  logic [COLS*PIXEL-1:0]         ref_row3;
  logic [COLS*PIXEL-1:0]         ref_row4;
  logic [COLS*PIXEL-1:0]         ref_row5;
  logic [COLS*PIXEL-1:0]         ref_row6;
  logic [COLS*PIXEL-1:0]         ref_row7;
  logic [COLS*PIXEL-1:0]         ref_row8;

  modport master (
    output in_valid, ref_ou,
    input  out_valid, ref_row1, ref_row2, ref_row3, ref_row4,
           ref_row5, ref_row6, ref_row7, ref_row8
  );

  modport slave (
    input  in_valid, ref_ou,
    output out_valid, ref_row1, ref_row2, ref_row3, ref_row4,
           ref_row5, ref_row6, ref_row7, ref_row8
  );
endinterface

// File: rtl/row_separator.sv
// Splits a column-major 8x32 reference block into eight registered 32-pixel row buses (1-cycle latency).
// Optional macro ROW_SEP_ZERO_INVALID_EN: when defined, rows read as zero whenever out_valid is low.
module row_separator #(
  parameter int unsigned PIXEL = 8,
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  row_separator_if.slave bus
);

  localparam int unsigned ROW_W = COLS * PIXEL;
  localparam int unsigned COL_W = ROWS * PIXEL;

  logic [ROW_W-1:0] sep   [ROWS];
  logic [ROW_W-1:0] row_q [ROWS];
  logic [ROW_W-1:0] row_o [ROWS];
  logic             valid_q;

  // Row index k=0 is the top row and takes the most-significant pixel of each column word.
  always_comb begin
    for (int unsigned k = 0; k < ROWS; k++) begin
      sep[k] = '0;
      for (int unsigned j = 0; j < COLS; j++) begin
        sep[k][j*PIXEL +: PIXEL] = bus.ref_ou[j*COL_W + (ROWS-1-k)*PIXEL +: PIXEL];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      for (int unsigned k = 0; k < ROWS; k++) begin
        row_q[k] <= '0;
      end
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int unsigned k = 0; k < ROWS; k++) begin
          row_q[k] <= sep[k];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < ROWS; k++) begin
`ifdef ROW_SEP_ZERO_INVALID_EN
      row_o[k] = valid_q ? row_q[k] : '0;
`else
      row_o[k] = row_q[k];
`endif
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.ref_row1  = row_o[0];
  assign bus.ref_row2  = row_o[1];
  assign bus.ref_row3  = row_o[2];
  assign bus.ref_row4  = row_o[3];
  assign bus.ref_row5  = row_o[4];
  assign bus.ref_row6  = row_o[5];
  assign bus.ref_row7  = row_o[6];
  assign bus.ref_row8  = row_o[7];

endmodule

// File: tb/tb_row_separator.sv
// Self-checking bench for row_separator: table-driven vectors plus reset and back-to-back sequences.
module tb_row_separator;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  row_separator_if #(.PIXEL(8), .ROWS(8), .COLS(32)) bus ();

  row_separator #(.PIXEL(8), .ROWS(8), .COLS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          iv;
    logic [2047:0] ref_ou;
    logic          ov;
    logic [255:0]  row [8];
  } vec_t;

  vec_t vecs [6];

  function automatic logic [255:0] get_row(input int k);
    case (k)
      0: get_row = bus.ref_row1;
      1: get_row = bus.ref_row2;
      2: get_row = bus.ref_row3;
      3: get_row = bus.ref_row4;
      4: get_row = bus.ref_row5;
      5: get_row = bus.ref_row6;
      6: get_row = bus.ref_row7;
      default: get_row = bus.ref_row8;
    endcase
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [255:0] rows [8]);
    chk($sformatf("%s out_valid", tag), {255'd0, bus.out_valid}, {255'd0, ov});
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s row%0d", tag, k + 1), get_row(k), rows[k]);
  endtask

  task automatic drive(input logic iv, input logic [2047:0] blk);
    @(negedge clk);
    bus.in_valid = iv;
    bus.ref_ou   = blk;
    @(posedge clk);
    #1;
  endtask

  logic [255:0] zero_rows  [8];
  logic [255:0] ones_rows  [8];
  logic [255:0] ramp_rows  [8];
  logic [255:0] held_rows  [8];
  logic [2047:0] blk_ones, blk_col, blk_row, blk_dist, blk_junk;
  logic [255:0]  col_ramp;
  logic [63:0]   w;

  initial begin
    // Hand-built stimulus blocks.
    blk_ones = {32{64'hFFFFFFFF_00000000}};
    blk_row  = {32{64'h0102030405060708}};
    for (int c = 0; c < 32; c++) begin
      blk_col[c*64 +: 64] = {8{c[7:0]}};
      for (int p = 0; p < 8; p++) begin
        w[p*8 +: 8] = {c[4:0], p[2:0]};
      end
      blk_dist[c*64 +: 64] = w;
      col_ramp[c*8 +: 8]   = c[7:0];
    end
    blk_junk = {64{32'hDEADBEEF}};

    for (int k = 0; k < 8; k++) begin
      zero_rows[k] = '0;
      ones_rows[k] = (k < 4) ? '1 : '0;
      ramp_rows[k] = {32{8'(k + 1)}};
    end

    // Vector table.
    vecs[0].iv = 1'b1; vecs[0].ref_ou = blk_ones; vecs[0].ov = 1'b1;
    vecs[1].iv = 1'b1; vecs[1].ref_ou = blk_col;  vecs[1].ov = 1'b1;
    vecs[2].iv = 1'b1; vecs[2].ref_ou = blk_row;  vecs[2].ov = 1'b1;
    vecs[3].iv = 1'b1; vecs[3].ref_ou = blk_dist; vecs[3].ov = 1'b1;
    vecs[4].iv = 1'b0; vecs[4].ref_ou = blk_junk; vecs[4].ov = 1'b0;
    vecs[5].iv = 1'b1; vecs[5].ref_ou = blk_row;  vecs[5].ov = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vecs[0].row[k] = ones_rows[k];
      vecs[1].row[k] = col_ramp;
      vecs[2].row[k] = ramp_rows[k];
      for (int j = 0; j < 32; j++)
        vecs[3].row[k][j*8 +: 8] = {j[4:0], 3'(7 - k)};
`ifdef ROW_SEP_ZERO_INVALID_EN
      vecs[4].row[k] = '0;
`else
      vecs[4].row[k] = vecs[3].row[k];
`endif
      vecs[5].row[k] = ramp_rows[k];
    end

    // Reset state, then release with in_valid low.
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.ref_ou   = blk_junk;
    @(posedge clk);
    #1;
    chk_all("reset", 1'b0, zero_rows);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post-reset idle", 1'b0, zero_rows);

    // Table: consecutive vectors exercise back-to-back acceptance.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].iv, vecs[i].ref_ou);
      chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].row);
    end

    // Two back-to-back blocks, then idle: rows hold block 2.
    drive(1'b1, blk_ones);
    chk_all("b2b blk1", 1'b1, ones_rows);
    drive(1'b1, blk_row);
    chk_all("b2b blk2", 1'b1, ramp_rows);
    drive(1'b0, blk_ones);
`ifdef ROW_SEP_ZERO_INVALID_EN
    held_rows = zero_rows;
`else
    held_rows = ramp_rows;
`endif
    chk_all("b2b idle", 1'b0, held_rows);
    drive(1'b0, blk_col);
    chk_all("b2b idle2", 1'b0, held_rows);

    // Asynchronous reset mid-stream: clears before the next clock edge.
    drive(1'b1, blk_ones);
    chk_all("pre-async", 1'b1, ones_rows);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async clear", 1'b0, zero_rows);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("after async idle", 1'b0, zero_rows);
    drive(1'b1, blk_row);
    chk_all("first post-reset blk", 1'b1, ramp_rows);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
